m_irq_ctrl: RTL

M_IRQ_CTRL -- requirements
Module: m_irq_ctrl

---
 rtl/m_irq_pkg.sv | 16 +
 rtl/m_prio_enc.sv | 25 ++
 rtl/m_irq_ctrl.sv | 87 ++++++++
 3 files changed

// File: rtl/m_irq_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, default width,
// and the CPU opcodes that drive the acknowledge/return handshakes.
package m_irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

  localparam int WORD_DEF = 16;

  localparam logic [3:0] INTERRUPT = 4'b0111;
  localparam logic [3:0] RETURN    = 4'b0110;

endpackage

// File: rtl/m_prio_enc.sv
// Combinational priority encoder: the lowest set bit wins.
module m_prio_enc
  import m_irq_pkg::*;
#(
  parameter int WORD  = WORD_DEF,
  parameter int VEC_W = $clog2(WORD)
) (
  input  logic [WORD-1:0]  req,
  output logic [VEC_W-1:0] idx,
  output logic             valid
);

  // Scanning from the top lets the last hit, the lowest index, win.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = WORD - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = VEC_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/m_irq_ctrl.sv
// Edge-triggered interrupt controller with pending/overflow tracking and a
// single-level IDLE -> REQ -> SERVICE handshake toward the CPU FSM.
module m_irq_ctrl
  import m_irq_pkg::*;
#(
  parameter int WORD  = WORD_DEF,
  parameter int VEC_W = $clog2(WORD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WORD-1:0]  irq_src,
  input  logic [WORD-1:0]  IMASK,
  input  logic             global_en,
  input  logic             irq_ack,
  input  logic             irq_ret,
  input  logic             ovf_clr,
  output logic             irq_req,
  output logic [VEC_W-1:0] irq_vec,
  output logic             in_service,
  output logic [WORD-1:0]  pending,
  output logic [WORD-1:0]  overflow
);

  irq_state_t       state, state_nxt;
  logic [VEC_W-1:0] vec_nxt;
  logic [WORD-1:0]  src_d;
  logic [WORD-1:0]  src_edge;
  logic [WORD-1:0]  ack_clr;
  logic [WORD-1:0]  ovf_set;
  logic [VEC_W-1:0] enc_idx;
  logic             enc_valid;

  m_prio_enc #(.WORD(WORD), .VEC_W(VEC_W)) u_prio_enc (
    .req   (pending & IMASK),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  // A coincident edge on the acknowledged source re-arms it and is not a lost edge.
  always_comb begin
    src_edge = irq_src & ~src_d;
    ack_clr  = '0;
    if (state == REQ && irq_ack) ack_clr[irq_vec] = 1'b1;
    ovf_set  = src_edge & pending & ~ack_clr;
  end

  always_comb begin
    state_nxt = state;
    vec_nxt   = irq_vec;
    unique case (state)
      IDLE: begin
        if (global_en && enc_valid) begin
          state_nxt = REQ;
          vec_nxt   = enc_idx;
        end
      end
      REQ: begin
        if (irq_ack)                          state_nxt = SERVICE;
        else if (!IMASK[irq_vec] || !global_en) state_nxt = IDLE;
      end
      SERVICE: begin
        if (irq_ret) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      irq_vec  <= '0;
      src_d    <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      state    <= state_nxt;
      irq_vec  <= vec_nxt;
      src_d    <= irq_src;
      pending  <= (pending & ~ack_clr) | src_edge;
      overflow <= ovf_clr ? ovf_set : (overflow | ovf_set);
    end
  end

  assign irq_req    = (state == REQ);
  assign in_service = (state == SERVICE);

endmodule
